regfile_sb: RTL and testbench

Parametrised register file for the pipelined LEGv8 datapath with a self-initialising reset sequencer, write-to-read bypass, and a per-register pending-write scoreboard. It sits in the decode stage. Reads return the write-back value of the same cycle. The scoreboard tells hazard logic which source registers still await a write-back from an in-flight instruction.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_sb_if.sv | 36 +++
 rtl/regfile_init_seq.sv | 74 +++++++
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the LEGv8 decode-stage register file.
package regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    // Maps the INIT_MODE parameter: 0 = all zero, 1 = register i holds i.
    typedef enum {
        INIT_ZERO,
        INIT_INDEX
    } init_mode_t;

    // Index width for a register count; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nregs);
        return (nregs <= 1) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage bus of the register file: write-back, two read ports, issue and hazard flags.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned N     = 64,
    parameter int unsigned NREGS = 32
);

    localparam int unsigned AW = idx_width(NREGS);

    logic          we3;
    logic [AW-1:0] wa3;
    logic [N-1:0]  wd3;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          busy1;
    logic          busy2;
    logic          init_busy;

    // Pipeline side: drives write-back, read indices and issue.
    modport master (
        output we3, wa3, wd3, ra1, ra2, iss_valid, iss_rd,
        input  rd1, rd2, busy1, busy2, init_busy
    );

    // Register file side.
    modport slave (
        input  we3, wa3, wd3, ra1, ra2, iss_valid, iss_rd,
        output rd1, rd2, busy1, busy2, init_busy
    );

endinterface

// File: rtl/regfile_init_seq.sv
// Reset sequencer: walks every register index once after reset, emitting
// the initial value on a dedicated write port, then parks in RUN.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned ZERO_REG  = 31,
    parameter int unsigned INIT_MODE = 1,
    localparam int unsigned AW       = idx_width(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          init_busy_o,
    output logic          init_we_o,
    output logic [AW-1:0] init_wa_o,
    output logic [N-1:0]  init_wd_o
);

    localparam init_mode_t MODE = init_mode_t'(INIT_MODE);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // One register per edge; the edge that writes the last index releases the pipeline.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        init_we_o = 1'b0;
        unique case (state_q)
            INIT: begin
                init_we_o = !reset;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_comb begin
        init_wd_o = '0;
        if (MODE == INIT_INDEX && cnt_q != ZERO_IDX) begin
            init_wd_o = N'(cnt_q);
        end
    end

    assign init_wa_o   = cnt_q;
    assign init_busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// LEGv8 register file with write-to-read bypass, self-initialising reset
// sequencer and a per-register pending-write scoreboard for hazard detection.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned N         = 64,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned ZERO_REG  = 31,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  rf_if
);

    localparam int unsigned   AW       = idx_width(NREGS);
    localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

    logic          init_busy;
    logic          init_we;
    logic [AW-1:0] init_wa;
    logic [N-1:0]  init_wd;
    logic          run_c;

    logic          wr_en_c;
    logic [AW-1:0] wr_addr_c;
    logic [N-1:0]  wr_data_c;

    logic [N-1:0]     regs_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic [N-1:0] rd1_c, rd2_c;
    logic         busy1_c, busy2_c;

    regfile_init_seq #(
        .N         (N),
        .NREGS     (NREGS),
        .ZERO_REG  (ZERO_REG),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk         (clk),
        .reset       (reset),
        .init_busy_o (init_busy),
        .init_we_o   (init_we),
        .init_wa_o   (init_wa),
        .init_wd_o   (init_wd)
    );

    assign run_c = !init_busy;

    // Init port has priority; write-back is only honoured once running.
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (init_we) begin
            wr_en_c   = 1'b1;
            wr_addr_c = init_wa;
            wr_data_c = init_wd;
        end else if (run_c && !reset && rf_if.we3 && rf_if.wa3 != ZERO_IDX) begin
            wr_en_c   = 1'b1;
            wr_addr_c = rf_if.wa3;
            wr_data_c = rf_if.wd3;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            regs_q[wr_addr_c] <= wr_data_c;
        end
    end

    // A fresh issue to a register outranks a write-back retiring an older producer.
    always_comb begin
        pend_d = pend_q;
        if (run_c) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                pend_d[i] = (rf_if.iss_valid && rf_if.iss_rd == AW'(i) && i != int'(ZERO_REG))
                         || (pend_q[i] && !(rf_if.we3 && rf_if.wa3 == AW'(i)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rd1_c = '0;
        if (run_c && rf_if.ra1 != ZERO_IDX) begin
            rd1_c = (rf_if.we3 && rf_if.wa3 == rf_if.ra1) ? rf_if.wd3 : regs_q[rf_if.ra1];
        end
    end

    always_comb begin
        rd2_c = '0;
        if (run_c && rf_if.ra2 != ZERO_IDX) begin
            rd2_c = (rf_if.we3 && rf_if.wa3 == rf_if.ra2) ? rf_if.wd3 : regs_q[rf_if.ra2];
        end
    end

    // A same-cycle write-back to the source is forwarded, so it is no longer a hazard.
    always_comb begin
        busy1_c = run_c && rf_if.ra1 != ZERO_IDX && pend_q[rf_if.ra1]
               && !(rf_if.we3 && rf_if.wa3 == rf_if.ra1);
        busy2_c = run_c && rf_if.ra2 != ZERO_IDX && pend_q[rf_if.ra2]
               && !(rf_if.we3 && rf_if.wa3 == rf_if.ra2);
    end

    assign rf_if.rd1       = rd1_c;
    assign rf_if.rd2       = rd2_c;
    assign rf_if.busy1     = busy1_c;
    assign rf_if.busy2     = busy2_c;
    assign rf_if.init_busy = init_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic, with every
// cycle's outputs checked by a scoreboard fed from a behavioural model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int unsigned N     = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned ZR    = 31;
    localparam int unsigned AW    = 5;

    typedef struct packed {
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic         b1;
        logic         b2;
        logic         ib;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.N(N), .NREGS(NREGS)) rf();

    regfile_sb #(
        .N         (N),
        .NREGS     (NREGS),
        .ZERO_REG  (ZR),
        .INIT_MODE (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rf_if (rf)
    );

    int vectors    = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    // Reference model: architectural contents, pending set, edges of INIT left.
    logic [N-1:0] mem [NREGS];
    bit           pend [NREGS];
    int unsigned  init_left = NREGS;

    function automatic logic [N-1:0] model_rd(input logic [AW-1:0] a);
        if (init_left != 0 || a == AW'(ZR)) return '0;
        if (rf.we3 && rf.wa3 == a) return rf.wd3;
        return mem[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        return init_left == 0 && a != AW'(ZR) && pend[a] && !(rf.we3 && rf.wa3 == a);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.rd1 = model_rd(rf.ra1);
        e.rd2 = model_rd(rf.ra2);
        e.b1  = model_busy(rf.ra1);
        e.b2  = model_busy(rf.ra2);
        e.ib  = (init_left != 0);
        return e;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [N-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic iv, input logic [AW-1:0] ir);
        reset        = r;
        rf.we3       = we;
        rf.wa3       = wa;
        rf.wd3       = wd;
        rf.ra1       = a1;
        rf.ra2       = a2;
        rf.iss_valid = iv;
        rf.iss_rd    = ir;
        exp_q.push_back(expect_now());
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        drive(1'b0, 1'b0, '0, '0, a1, a2, 1'b0, '0);
    endtask

    // Advance one edge and apply its effect to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            init_left = NREGS;
            for (int i = 0; i < int'(NREGS); i++) pend[i] = 1'b0;
        end else if (init_left != 0) begin
            init_left--;
            if (init_left == 0)
                for (int i = 0; i < int'(NREGS); i++) mem[i] = (i == int'(ZR)) ? '0 : N'(i);
        end else begin
            if (rf.we3 && rf.wa3 != AW'(ZR)) mem[rf.wa3] = rf.wd3;
            if (rf.we3) pend[rf.wa3] = 1'b0;
            if (rf.iss_valid && rf.iss_rd != AW'(ZR)) pend[rf.iss_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [AW-1:0] pick();
        return ($urandom_range(0, 4) == 0) ? AW'(ZR) : AW'($urandom_range(0, 7));
    endfunction

    // Scoreboard monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (rf.rd1 !== e.rd1 || rf.rd2 !== e.rd2 || rf.busy1 !== e.b1 ||
                    rf.busy2 !== e.b2 || rf.init_busy !== e.ib) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t: got rd1=%h rd2=%h b1=%b b2=%b ib=%b, expected rd1=%h rd2=%h b1=%b b2=%b ib=%b",
                             $time, rf.rd1, rf.rd2, rf.busy1, rf.busy2, rf.init_busy,
                             e.rd1, e.rd2, e.b1, e.b2, e.ib);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; rf.we3 = 1'b0; rf.wa3 = '0; rf.wd3 = '0;
        rf.ra1 = '0; rf.ra2 = '0; rf.iss_valid = 1'b0; rf.iss_rd = '0;
        for (int i = 0; i < int'(NREGS); i++) begin mem[i] = '0; pend[i] = 1'b0; end
        tick();

        // Reset held two edges, then INIT must span exactly NREGS edges.
        drive(1'b1, 1'b0, '0, '0, 5'd5, 5'd31, 1'b0, '0);
        chk("reset_init_busy", N'(rf.init_busy), N'(1));
        chk("reset_rd1", rf.rd1, '0);
        tick();
        for (int k = 0; k < int'(NREGS); k++) begin
            drive(1'b0, 1'b1, 5'd3, 64'hABCD, 5'd5, 5'd31, 1'b1, 5'd3);
            chk($sformatf("init_busy_edge%0d", k), N'(rf.init_busy), N'(1));
            tick();
        end
        idle(5'd5, 5'd31);
        chk("init_done", N'(rf.init_busy), N'(0));
        chk("init_rd1_r5", rf.rd1, 64'd5);
        chk("init_rd2_r31", rf.rd2, '0);
        chk("init_ignored_iss", N'(rf.busy1), N'(0));
        tick();

        // Same-cycle bypass, then the stored value.
        drive(1'b0, 1'b1, 5'd7, 64'hDEAD, 5'd7, 5'd6, 1'b0, '0);
        chk("bypass_rd1", rf.rd1, 64'hDEAD);
        chk("bypass_rd2_r6", rf.rd2, 64'd6);
        tick();
        idle(5'd7, 5'd0);
        chk("stored_rd1", rf.rd1, 64'hDEAD);
        tick();

        // Zero register: write and issue both have no effect.
        drive(1'b0, 1'b1, 5'd31, 64'hFF, 5'd31, 5'd31, 1'b1, 5'd31);
        chk("zero_rd1", rf.rd1, '0);
        chk("zero_busy1", N'(rf.busy1), N'(0));
        tick();
        idle(5'd31, 5'd31);
        chk("zero_rd1_after", rf.rd1, '0);
        chk("zero_busy1_after", N'(rf.busy1), N'(0));
        tick();

        // Scoreboard set, resolve by bypass, then cleared.
        drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd0, 1'b1, 5'd3);
        chk("iss_no_same_cycle_busy", N'(rf.busy1), N'(0));
        tick();
        idle(5'd3, 5'd3);
        chk("sb_busy1_set", N'(rf.busy1), N'(1));
        chk("sb_busy2_set", N'(rf.busy2), N'(1));
        tick();
        drive(1'b0, 1'b1, 5'd3, 64'h1234, 5'd3, 5'd0, 1'b0, '0);
        chk("sb_busy1_bypass", N'(rf.busy1), N'(0));
        chk("sb_rd1_bypass", rf.rd1, 64'h1234);
        tick();
        idle(5'd3, 5'd0);
        chk("sb_busy1_clear", N'(rf.busy1), N'(0));
        tick();

        // Simultaneous set and clear on one register: set wins, data still written.
        drive(1'b0, 1'b0, '0, '0, 5'd4, 5'd0, 1'b1, 5'd4);
        tick();
        drive(1'b0, 1'b1, 5'd4, 64'd9, 5'd0, 5'd0, 1'b1, 5'd4);
        tick();
        idle(5'd4, 5'd4);
        chk("setclr_busy1", N'(rf.busy1), N'(1));
        chk("setclr_rd1", rf.rd1, 64'd9);
        tick();
        drive(1'b0, 1'b1, 5'd4, 64'd10, 5'd0, 5'd0, 1'b0, '0);
        tick();

        // Reset mid-RUN restores initial contents and clears pending bits.
        drive(1'b0, 1'b1, 5'd2, 64'h55, 5'd2, 5'd0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 5'd2, 5'd6, 1'b1, 5'd6);
        chk("pre_reset_rd1", rf.rd1, 64'h55);
        tick();
        idle(5'd2, 5'd6);
        chk("pre_reset_busy2", N'(rf.busy2), N'(1));
        tick();
        drive(1'b1, 1'b0, '0, '0, 5'd2, 5'd6, 1'b0, '0);
        tick();
        for (int k = 0; k < int'(NREGS); k++) begin
            idle(5'd2, 5'd6);
            tick();
        end
        idle(5'd2, 5'd6);
        chk("rst_rd1_r2", rf.rd1, 64'd2);
        chk("rst_rd2_r6", rf.rd2, 64'd6);
        chk("rst_busy2", N'(rf.busy2), N'(0));
        chk("rst_init_busy", N'(rf.init_busy), N'(0));
        tick();

        // Randomized traffic concentrated on a few registers, with rare resets.
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 2) != 0), pick(),
                  {$urandom, $urandom}, pick(), pick(), 1'($urandom_range(0, 1)), pick());
            tick();
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
